// File: rtl/spi_adc_multi_receiver.sv
// spi_adc_multi_receiver: drives one shared cs/sck pair to N_CH SPI ADCs and
// captures one result per channel per frame, with a GAP of cs-high cycles
// between frames.
// Build macro SPI_ADC_MULTI_RECEIVER_AVG_EN: when defined, each channel's
// output is the truncated mean of its last four extracted samples instead of
// the raw sample.

// Per-channel capture: shift register, result extraction, optional averaging.
module spi_adc_multi_receiver_lane #(
    parameter int DATA_W   = 12,
    parameter int DATA_LSB = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              sample_i,
    input  logic              load_i,
    input  logic              sdo_i,
    output logic [DATA_W-1:0] value_o
);
    // Only bits up to the result MSB are ever read, so older frame bits
    // simply fall off the top of the register.
    localparam int SH_W = DATA_LSB + DATA_W;

    logic [SH_W-1:0]   shift_q;
    logic [DATA_W-1:0] sample;
    logic [DATA_W-1:0] value_d;
    logic [DATA_W-1:0] value_q;

    // MSB-first capture: each new bit enters at position 0.
    always_ff @(posedge clock) begin
        if (reset) begin
            shift_q <= '0;
        end else if (sample_i) begin
            shift_q <= (shift_q << 1) | SH_W'(sdo_i);
        end
    end

    assign sample = shift_q[SH_W-1:DATA_LSB];

`ifdef SPI_ADC_MULTI_RECEIVER_AVG_EN
    logic [DATA_W-1:0] hist0_q;
    logic [DATA_W-1:0] hist1_q;
    logic [DATA_W-1:0] hist2_q;
    logic [DATA_W+1:0] sum;

    // Two extra bits hold the sum of four full-scale samples without wrap.
    assign sum = {2'b00, sample} + {2'b00, hist0_q} + {2'b00, hist1_q} + {2'b00, hist2_q};
    assign value_d = DATA_W'(sum >> 2);

    // History of the three previous samples, advanced once per frame.
    always_ff @(posedge clock) begin
        if (reset) begin
            hist0_q <= '0;
            hist1_q <= '0;
            hist2_q <= '0;
        end else if (load_i) begin
            hist2_q <= hist1_q;
            hist1_q <= hist0_q;
            hist0_q <= sample;
        end
    end
`else
    assign value_d = sample;
`endif

    // Result register: updated only at frame end, held otherwise.
    always_ff @(posedge clock) begin
        if (reset) begin
            value_q <= '0;
        end else if (load_i) begin
            value_q <= value_d;
        end
    end

    assign value_o = value_q;
endmodule

module spi_adc_multi_receiver #(
    parameter int N_CH       = 2,
    parameter int FRAME_BITS = 16,
    parameter int DATA_W     = 12,
    parameter int DATA_LSB   = 1,
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYCLES = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [N_CH-1:0]          sdo,
    output logic                     cs,
    output logic                     sck,
    output logic [N_CH*DATA_W-1:0]   value,
    output logic                     valid,
    output logic                     busy
);
    localparam int HALF  = CLK_DIV / 2;
    localparam int PH_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    if (DATA_LSB < 0 || DATA_W < 1 || DATA_LSB + DATA_W > FRAME_BITS) begin : g_bad_slice
        $error("spi_adc_multi_receiver: result field does not fit in the frame");
    end
    if (CLK_DIV < 2 || (CLK_DIV % 2) != 0) begin : g_bad_div
        $error("spi_adc_multi_receiver: CLK_DIV must be even and at least 2");
    end
    if (GAP_CYCLES < 1) begin : g_bad_gap
        $error("spi_adc_multi_receiver: GAP_CYCLES must be at least 1");
    end
    if (N_CH < 1) begin : g_bad_ch
        $error("spi_adc_multi_receiver: N_CH must be at least 1");
    end

    typedef enum logic [1:0] {IDLE, ACTIVE, GAP} state_t;

    state_t             state_q, state_d;
    logic [PH_W-1:0]    phase_q, phase_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic               cs_q, cs_d;
    logic               sck_q, sck_d;
    logic               valid_q;
    logic               sample_en;
    logic               load_en;

    // Sequencer: phase within a bit, bit within a frame, cycle within GAP.
    // cs/sck are derived from the next state so they leave the flops
    // aligned with the state they describe.
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        bit_d     = bit_q;
        gap_d     = gap_q;
        sample_en = 1'b0;
        load_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = ACTIVE;
                    phase_d = '0;
                    bit_d   = '0;
                end
            end
            ACTIVE: begin
                // Last sck-low cycle of the bit period: the ADC has had the
                // whole low half to settle its output.
                sample_en = (phase_q == PH_W'(HALF - 1));
                if (phase_q == PH_W'(CLK_DIV - 1)) begin
                    phase_d = '0;
                    if (bit_q == BIT_W'(FRAME_BITS - 1)) begin
                        state_d = GAP;
                        bit_d   = '0;
                        gap_d   = '0;
                        load_en = 1'b1;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            GAP: begin
                if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
                    gap_d   = '0;
                    phase_d = '0;
                    state_d = enable ? ACTIVE : IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        cs_d  = (state_d != ACTIVE);
        sck_d = (state_d != ACTIVE) || (phase_d >= PH_W'(HALF));
    end

    // State, counters and registered outputs; reset dominates everything.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            phase_q <= '0;
            bit_q   <= '0;
            gap_q   <= '0;
            cs_q    <= 1'b1;
            sck_q   <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            bit_q   <= bit_d;
            gap_q   <= gap_d;
            cs_q    <= cs_d;
            sck_q   <= sck_d;
            valid_q <= load_en;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_lane
        spi_adc_multi_receiver_lane #(
            .DATA_W   (DATA_W),
            .DATA_LSB (DATA_LSB)
        ) u_lane (
            .clock    (clock),
            .reset    (reset),
            .sample_i (sample_en),
            .load_i   (load_en),
            .sdo_i    (sdo[i]),
            .value_o  (value[i*DATA_W +: DATA_W])
        );
    end

    assign cs    = cs_q;
    assign sck   = sck_q;
    assign valid = valid_q;
    assign busy  = (state_q != IDLE);
endmodule

// File: tb/tb_spi_adc_multi_receiver.sv
// Bench for spi_adc_multi_receiver: a default-parameter instance (dut0) and a
// fast single-channel instance (dut1), each fed by an ADC model that shifts
// out a chosen word MSB first on every sck falling edge. Expected results are
// queued when a frame starts and compared when valid pulses.
`timescale 1ns/1ps
module tb_spi_adc_multi_receiver;
    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset0, enable0;
    logic [1:0]  sdo0 = '0;
    logic        cs0, sck0, valid0, busy0;
    logic [23:0] value0;

    logic        reset1, enable1;
    logic [0:0]  sdo1 = '0;
    logic        cs1, sck1, valid1, busy1;
    logic [15:0] value1;

    spi_adc_multi_receiver dut0 (
        .clock(clock), .reset(reset0), .enable(enable0), .sdo(sdo0),
        .cs(cs0), .sck(sck0), .value(value0), .valid(valid0), .busy(busy0)
    );

    spi_adc_multi_receiver #(
        .N_CH(1), .FRAME_BITS(16), .DATA_W(16), .DATA_LSB(0), .CLK_DIV(2), .GAP_CYCLES(1)
    ) dut1 (
        .clock(clock), .reset(reset1), .enable(enable1), .sdo(sdo1),
        .cs(cs1), .sck(sck1), .value(value1), .valid(valid1), .busy(busy1)
    );

    int vectors = 0;
    int miscompares = 0;

    logic [23:0] q0[$];
    logic [15:0] q1[$];
    logic [15:0] w0a, w0b, w1;

    // ADC model for dut0: latch words at cs fall, push expectation, shift out on sck fall.
    logic        m0_pcs = 1'b1, m0_psck = 1'b1;
    int          m0_idx = 0;
    logic [15:0] m0_c0, m0_c1;
    logic [23:0] m0_exp;
`ifdef SPI_ADC_MULTI_RECEIVER_AVG_EN
    logic [11:0] m0_h [2][3];
    logic [11:0] m0_s;
    logic [13:0] m0_sum;
`endif
    always @(posedge clock) begin
        #1;
        if (reset0) begin
            m0_idx = 0;
            sdo0 = '0;
`ifdef SPI_ADC_MULTI_RECEIVER_AVG_EN
            for (int c = 0; c < 2; c++) for (int k = 0; k < 3; k++) m0_h[c][k] = '0;
`endif
        end else begin
            if (m0_pcs && !cs0) begin
                m0_idx = 0;
                m0_c0 = w0a;
                m0_c1 = w0b;
                m0_exp = {m0_c1[12:1], m0_c0[12:1]};
`ifdef SPI_ADC_MULTI_RECEIVER_AVG_EN
                for (int c = 0; c < 2; c++) begin
                    m0_s = m0_exp[c*12 +: 12];
                    m0_sum = 14'(m0_s) + 14'(m0_h[c][0]) + 14'(m0_h[c][1]) + 14'(m0_h[c][2]);
                    m0_exp[c*12 +: 12] = m0_sum[13:2];
                    m0_h[c][2] = m0_h[c][1];
                    m0_h[c][1] = m0_h[c][0];
                    m0_h[c][0] = m0_s;
                end
`endif
                q0.push_back(m0_exp);
            end
            if (m0_psck && !sck0 && !cs0 && m0_idx < 16) begin
                sdo0 = {m0_c1[15-m0_idx], m0_c0[15-m0_idx]};
                m0_idx++;
            end
        end
        m0_pcs = cs0;
        m0_psck = sck0;
    end

    // ADC model for dut1 (one channel, 16-bit result at bit 0).
    logic        m1_pcs = 1'b1, m1_psck = 1'b1;
    int          m1_idx = 0;
    logic [15:0] m1_c;
    logic [15:0] m1_exp;
`ifdef SPI_ADC_MULTI_RECEIVER_AVG_EN
    logic [15:0] m1_h [3];
    logic [17:0] m1_sum;
`endif
    always @(posedge clock) begin
        #1;
        if (reset1) begin
            m1_idx = 0;
            sdo1 = '0;
`ifdef SPI_ADC_MULTI_RECEIVER_AVG_EN
            for (int k = 0; k < 3; k++) m1_h[k] = '0;
`endif
        end else begin
            if (m1_pcs && !cs1) begin
                m1_idx = 0;
                m1_c = w1;
                m1_exp = m1_c;
`ifdef SPI_ADC_MULTI_RECEIVER_AVG_EN
                m1_sum = 18'(m1_c) + 18'(m1_h[0]) + 18'(m1_h[1]) + 18'(m1_h[2]);
                m1_exp = m1_sum[17:2];
                m1_h[2] = m1_h[1];
                m1_h[1] = m1_h[0];
                m1_h[0] = m1_c;
`endif
                q1.push_back(m1_exp);
            end
            if (m1_psck && !sck1 && !cs1 && m1_idx < 16) begin
                sdo1 = m1_c[15-m1_idx];
                m1_idx++;
            end
        end
        m1_pcs = cs1;
        m1_psck = sck1;
    end

    // Inputs change and outputs are read 2 ns after the edge, after the models.
    task automatic tick;
        @(posedge clock);
        #2;
    endtask

    task automatic test_reset;
        reset0 = 1'b1; enable0 = 1'b1;
        w0a = 16'h0ABC << 1; w0b = 16'h0123 << 1;
        repeat (3) tick();
        vectors++;
        if ({cs0, sck0, busy0, valid0} !== 4'b1100 || value0 !== 24'h0) begin
            miscompares++;
            $display("FAIL reset_state: cs,sck,busy,valid=%b value=%h, want 1100 value 000000",
                     {cs0, sck0, busy0, valid0}, value0);
        end
        reset0 = 1'b0;
        tick();
        vectors++;
        if (cs0 !== 1'b0 || sck0 !== 1'b0 || busy0 !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_release: cs=%b sck=%b busy=%b, want 0 0 1", cs0, sck0, busy0);
        end
    endtask

    // Two default frames: cs/sck waveform per cycle, valid placement, values, period.
    task automatic test_basic;
        int pos = 0, cyc = 0, last_fall = 0, nval = 0;
        logic pcs = 1'b0;
        logic exp_cs, exp_sck;
        logic [23:0] expv;
        repeat (140) begin
            tick(); cyc++;
            if (pcs && !cs0) begin
                vectors++;
                if (cyc - last_fall != 68) begin
                    miscompares++;
                    $display("FAIL basic_period: got %0d cycles, want 68", cyc - last_fall);
                end
                last_fall = cyc; pos = 0;
            end else pos++;
            exp_cs  = (pos >= 64);
            exp_sck = (pos >= 64) ? 1'b1 : ((pos % 4) >= 2);
            vectors++;
            if (cs0 !== exp_cs || sck0 !== exp_sck) begin
                miscompares++;
                $display("FAIL basic_wave pos %0d: cs=%b sck=%b, want cs=%b sck=%b",
                         pos, cs0, sck0, exp_cs, exp_sck);
            end
            if (valid0) begin
                nval++;
                vectors++;
                if (pos != 64) begin
                    miscompares++;
                    $display("FAIL basic_valid_pos: valid at frame cycle %0d, want 64", pos);
                end
                vectors++;
                if (q0.size() == 0) begin
                    miscompares++;
                    $display("FAIL basic_value: valid with value %h, no frame expected", value0);
                end else begin
                    expv = q0.pop_front();
                    if (value0 !== expv) begin
                        miscompares++;
                        $display("FAIL basic_value: got %h, want %h", value0, expv);
                    end
                end
`ifndef SPI_ADC_MULTI_RECEIVER_AVG_EN
                vectors++;
                if (value0 !== 24'h123ABC) begin
                    miscompares++;
                    $display("FAIL basic_const: got %h, want 123abc", value0);
                end
`endif
            end
            pcs = cs0;
        end
        vectors++;
        if (nval != 2) begin
            miscompares++;
            $display("FAIL basic_valid_count: got %0d, want 2", nval);
        end
    endtask

    // Enable dropped at frame cycle 4: frame and GAP complete, then IDLE.
    task automatic test_enable_drop;
        int k = 0, nval = 0, nfall = 0, idle_at = -1;
        logic pcs;
        logic [23:0] expv;
        pcs = cs0;
        enable0 = 1'b0;
        w0a = 16'h1E3C; w0b = 16'h05A6;
        repeat (100) begin
            tick(); k++;
            if (pcs && !cs0) nfall++;
            if (!busy0 && idle_at < 0) idle_at = k;
            if (valid0) begin
                nval++;
                vectors++;
                expv = (q0.size() != 0) ? q0.pop_front() : 24'hxxxxxx;
                if (value0 !== expv) begin
                    miscompares++;
                    $display("FAIL drop_value: got %h, want %h", value0, expv);
                end
            end
            pcs = cs0;
        end
        vectors++;
        if (nval != 1 || nfall != 0 || idle_at != 64) begin
            miscompares++;
            $display("FAIL drop_complete: valids=%0d falls=%0d idle_at=%0d, want 1 0 64",
                     nval, nfall, idle_at);
        end
        vectors++;
        if (busy0 !== 1'b0 || cs0 !== 1'b1 || sck0 !== 1'b1) begin
            miscompares++;
            $display("FAIL drop_idle: busy=%b cs=%b sck=%b, want 0 1 1", busy0, cs0, sck0);
        end
        enable0 = 1'b1;
        tick();
        vectors++;
        if (cs0 !== 1'b0) begin
            miscompares++;
            $display("FAIL drop_restart: cs=%b one cycle after enable, want 0", cs0);
        end
    endtask

    // Reset at the start of bit 7 aborts the frame with no valid pulse.
    task automatic test_reset_midframe;
        int bad = 0;
        repeat (28) tick();
        reset0 = 1'b1;
        tick();
        vectors++;
        if (cs0 !== 1'b1 || sck0 !== 1'b1 || valid0 !== 1'b0 || busy0 !== 1'b0 || value0 !== 24'h0) begin
            miscompares++;
            $display("FAIL midreset_state: cs=%b sck=%b valid=%b busy=%b value=%h, want 1 1 0 0 0",
                     cs0, sck0, valid0, busy0, value0);
        end
        repeat (2) tick();
        enable0 = 1'b0;
        reset0 = 1'b0;
        q0.delete();
        repeat (80) begin
            tick();
            if (valid0 !== 1'b0 || value0 !== 24'h0 || cs0 !== 1'b1) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL midreset_quiet: %0d cycles with valid/value/cs activity, want 0", bad);
        end
    endtask

    // Fast configuration: 2-cycle sck, 1-cycle gap, full 16-bit result.
    task automatic test_fast;
        int pos = 0, cyc = 0, last_fall = 0, nval = 0;
        logic pcs = 1'b0;
        logic [15:0] expv;
        w1 = 16'hFFFF;
        enable1 = 1'b1;
        reset1 = 1'b0;
        tick();
        vectors++;
        if (cs1 !== 1'b0) begin
            miscompares++;
            $display("FAIL fast_start: cs=%b, want 0", cs1);
        end
        repeat (70) begin
            tick(); cyc++;
            if (pcs && !cs1) begin
                vectors++;
                if (cyc - last_fall != 33) begin
                    miscompares++;
                    $display("FAIL fast_period: got %0d cycles, want 33", cyc - last_fall);
                end
                last_fall = cyc; pos = 0;
            end else pos++;
            if (valid1) begin
                vectors++;
                expv = (q1.size() != 0) ? q1.pop_front() : 16'hxxxx;
                if (value1 !== expv || pos != 32) begin
                    miscompares++;
                    $display("FAIL fast_value: got %h at cycle %0d, want %h at 32", value1, pos, expv);
                end
`ifndef SPI_ADC_MULTI_RECEIVER_AVG_EN
                vectors++;
                if (value1 !== ((nval == 0) ? 16'hFFFF : 16'h0000)) begin
                    miscompares++;
                    $display("FAIL fast_const: frame %0d got %h", nval, value1);
                end
`endif
                nval++;
                w1 = 16'h0000;
            end
            pcs = cs1;
        end
        vectors++;
        if (nval != 2) begin
            miscompares++;
            $display("FAIL fast_valid_count: got %0d, want 2", nval);
        end
        reset1 = 1'b1;
        enable1 = 1'b0;
    endtask

    // 100 continuous frames with random data: sck edges, sampling window, values.
    task automatic test_back_to_back;
        int pos = 0, nval = 0, nfall = 1, rises = 0, rises_low = 0;
        logic pcs = 1'b0, psck = 1'b0;
        logic [23:0] expv;
        w0a = 16'($urandom); w0b = 16'($urandom);
        enable0 = 1'b1;
        tick();
        vectors++;
        if (cs0 !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_start: cs=%b one cycle after enable, want 0", cs0);
        end
        w0a = 16'($urandom); w0b = 16'($urandom);
        repeat (100 * 68 + 20) begin
            tick();
            if (pcs && !cs0) begin
                nfall++; pos = 0;
                w0a = 16'($urandom); w0b = 16'($urandom);
                if (nfall == 100) enable0 = 1'b0;
            end else pos++;
            if (!psck && sck0) begin
                rises++;
                if (cs0 === 1'b0) rises_low++;
            end
            if (valid0) begin
                nval++;
                vectors++;
                if (rises != 16 || rises_low != 16 || pos != 64) begin
                    miscompares++;
                    $display("FAIL b2b_sck frame %0d: rises=%0d with_cs_low=%0d valid_at=%0d, want 16 16 64",
                             nval, rises, rises_low, pos);
                end
                rises = 0; rises_low = 0;
                vectors++;
                expv = (q0.size() != 0) ? q0.pop_front() : 24'hxxxxxx;
                if (value0 !== expv) begin
                    miscompares++;
                    $display("FAIL b2b_value frame %0d: got %h, want %h", nval, value0, expv);
                end
            end
            pcs = cs0;
            psck = sck0;
        end
        vectors++;
        if (nval != 100 || nfall != 100 || q0.size() != 0 || busy0 !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_count: valids=%0d frames=%0d pending=%0d busy=%b, want 100 100 0 0",
                     nval, nfall, q0.size(), busy0);
        end
    endtask

`ifdef SPI_ADC_MULTI_RECEIVER_AVG_EN
    // Running mean of 4, 8, 12, 16 from a cleared history.
    task automatic test_avg;
        int avg_exp [4] = '{1, 3, 6, 10};
        int nval = 0, nfall = 1;
        logic pcs = 1'b0;
        logic [23:0] expv;
        reset0 = 1'b1;
        repeat (2) tick();
        w0a = 16'd4 << 1; w0b = 16'h0;
        enable0 = 1'b1;
        reset0 = 1'b0;
        tick();
        w0a = 16'd8 << 1;
        repeat (4 * 68 + 10) begin
            tick();
            if (pcs && !cs0) begin
                nfall++;
                w0a = 16'(nfall + 1) * 16'd4 << 1;
                if (nfall == 4) enable0 = 1'b0;
            end
            if (valid0 && nval < 4) begin
                vectors++;
                expv = (q0.size() != 0) ? q0.pop_front() : 24'hxxxxxx;
                if (value0 !== expv || value0[11:0] !== 12'(avg_exp[nval])) begin
                    miscompares++;
                    $display("FAIL avg_value %0d: got %h, want %h (ch0 %0d)", nval, value0, expv, avg_exp[nval]);
                end
                nval++;
            end
            pcs = cs0;
        end
        vectors++;
        if (nval != 4) begin
            miscompares++;
            $display("FAIL avg_count: got %0d valids, want 4", nval);
        end
    endtask
`endif

    initial begin
        reset0 = 1'b1; enable0 = 1'b0;
        reset1 = 1'b1; enable1 = 1'b0;
        w0a = '0; w0b = '0; w1 = '0;
        test_reset();
        test_basic();
        test_enable_drop();
        test_reset_midframe();
        test_fast();
        test_back_to_back();
`ifdef SPI_ADC_MULTI_RECEIVER_AVG_EN
        test_avg();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
